// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic inter-stage pipeline register for the CPU pipeline.
// A DEPTH-entry FIFO skid buffer with valid/ready handshakes on both sides,
// a registered in_ready (upstream stall path is a flop), a synchronous
// flush for squash, and masking of payload/type when no entry is present.
// Optional performance counters are compiled in with PIPE_STAGE_PERF_EN.
module pipe_stage_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TYPE_W = 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [TYPE_W-1:0]          in_type,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [TYPE_W-1:0]          out_type,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]                stall_cnt,
    output logic [31:0]                bubble_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    // Occupancy needs to represent 0..DEPTH inclusive.
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    // Pointers index 0..DEPTH-1; keep at least one bit for DEPTH=1.
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

    // Entry storage; deliberately not reset, occupancy tracking masks it.
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [TYPE_W-1:0] type_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              in_ready_q, in_ready_d;

    logic              head_valid;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_data;
    logic [TYPE_W-1:0] head_type;

    // Wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : (p + PTR_ONE);
    endfunction

    assign head_valid = (count_q != '0);

    // Flush overrides both sides: the incoming beat is dropped and the
    // head is not considered consumed.
    assign push = in_valid & in_ready_q & ~flush;
    assign pop  = head_valid & out_ready & ~flush;

    // Next-state for pointers, occupancy and the registered ready.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
        // Ready is derived from next occupancy only, never from out_ready
        // in the same cycle, so it can be registered.
        in_ready_d = (count_d < DEPTH_C);
    end

    // Control state with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Write the accepted beat into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= in_data;
            type_mem[wr_ptr_q] <= in_type;
        end
    end

    assign head_data = data_mem[rd_ptr_q];
    assign head_type = type_mem[rd_ptr_q];

    // Bubbles present all-zero payload and type so downstream decode
    // never sees stale instruction-type bits.
    assign out_valid = head_valid;
    assign out_data  = head_data & {DATA_W{head_valid}};
    assign out_type  = head_type & {TYPE_W{head_valid}};
    assign in_ready  = in_ready_q;
    assign count     = count_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Saturating stall/bubble counters; only reset clears them, flush does not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (head_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (!head_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
